// File: rtl/ram16k_arbiter_pkg.sv
// Shared constants and the FSM state type for the RAM sequencer/arbiter.
package ram16k_arb_pkg;

    localparam int RAM_ADDR_W = 14;
    localparam int RAM_DEPTH  = 16384;
    localparam int WORD_W     = 16;

    // CLEAR: zero-fill sweep running; ARB: RAM port shared between requesters
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ram16k_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. Grant is combinational from req; the
// register remembers which port won last so a tie goes to the other one.
module rr_arb2
    import ram16k_arb_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic r_last;

    // Single requester wins outright; a tie goes to the port that did not win last
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = r_last ? 2'b01 : 2'b10;
        end
    end

    // Track the most recently granted port; reset to 1 so port 0 wins the first tie
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_last <= 1'b1;
        end else if (|gnt) begin
            r_last <= gnt[1];
        end
    end

endmodule

// File: rtl/ram16k_arbiter.sv
// Sequencer and two-port arbiter in front of the Hack 16K data RAM.
// After reset the RAM is swept to zero one word per cycle, then the single
// RAM port is shared round-robin between port 0 (CPU) and port 1 (loader).
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_CLEAR | writing zero to address clr_cnt each cycle, no grants
//   ST_ARB   | normal operation, RAM port follows the granted requester
module ram16k_arbiter
    import ram16k_arb_pkg::*;
#(
    parameter int ADDR_W         = RAM_ADDR_W,
    parameter int DATA_W         = WORD_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_N,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out,

    output logic              clear_busy
);

    localparam arb_state_t        RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
    localparam logic [ADDR_W-1:0] CLR_LAST  = '1;
    localparam logic [ADDR_W-1:0] CLR_STEP  = {{(ADDR_W-1){1'b0}}, 1'b1};

    arb_state_t        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;

    logic              w_in_arb;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_rd0;
    logic              w_rd1;

    assign w_in_arb = (r_state == ST_ARB);

    // The arbiter never sees requests during the sweep, so no grant can leak out
    assign w_req = {p1_req, p0_req} & {2{w_in_arb}};

    rr_arb2 u_rr_arb2 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .req   (w_req),
        .gnt   (w_gnt)
    );

    assign p0_gnt = w_gnt[0];
    assign p1_gnt = w_gnt[1];

    assign w_rd0 = w_gnt[0] & ~p0_we;
    assign w_rd1 = w_gnt[1] & ~p1_we;

    // Sequencer: sweep every address once, then hand over to arbitration
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= RST_STATE;
            r_clr_cnt  <= '0;
            clear_busy <= CLEAR_ON_RESET;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    // Wraps back to 0 on the last address, leaving it idle in ARB
                    r_clr_cnt <= r_clr_cnt + CLR_STEP;
                    if (r_clr_cnt == CLR_LAST) begin
                        r_state    <= ST_ARB;
                        clear_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_ARB;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

    // RAM port mux: sweep, granted port, or an idle port-0 view with no write
    always_comb begin
        ram_load    = 1'b0;
        ram_address = p0_addr;
        ram_in      = p0_wdata;
        if (!w_in_arb) begin
            ram_load    = 1'b1;
            ram_address = r_clr_cnt;
            ram_in      = '0;
        end else if (w_gnt[1]) begin
            ram_load    = p1_we;
            ram_address = p1_addr;
            ram_in      = p1_wdata;
        end else if (w_gnt[0]) begin
            ram_load    = p0_we;
        end
    end

    // Port 0 read return: capture at the grant edge, pulse valid for one cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p0_rvalid <= 1'b0;
            p0_rdata  <= '0;
        end else begin
            p0_rvalid <= w_rd0;
            if (w_rd0) begin
                p0_rdata <= ram_out;
            end
        end
    end

    // Port 1 read return: capture at the grant edge, pulse valid for one cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p1_rvalid <= 1'b0;
            p1_rdata  <= '0;
        end else begin
            p1_rvalid <= w_rd1;
            if (w_rd1) begin
                p1_rdata <= ram_out;
            end
        end
    end

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Bench for ram16k_arbiter: one instance with the zero-fill sweep enabled
// (_c) and one without (_a), each in front of its own behavioural RAM.
module tb_ram16k_arbiter;

    localparam int AW    = 14;
    localparam int DW    = 16;
    localparam int DEPTH = 16384;

    typedef struct {
        logic          r0;
        logic          w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1;
        logic          w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          g0;
        logic          g1;
    } vec_t;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } sb_t;

    logic clk;
    logic rst_n_a, rst_n_c;

    logic          p0_req_a, p0_we_a, p1_req_a, p1_we_a;
    logic [AW-1:0] p0_addr_a, p1_addr_a, ram_address_a;
    logic [DW-1:0] p0_wdata_a, p1_wdata_a, p0_rdata_a, p1_rdata_a, ram_in_a, ram_out_a;
    logic          p0_gnt_a, p1_gnt_a, p0_rvalid_a, p1_rvalid_a, ram_load_a, clear_busy_a;

    logic          p0_req_c, p0_we_c, p1_req_c, p1_we_c;
    logic [AW-1:0] p0_addr_c, p1_addr_c, ram_address_c;
    logic [DW-1:0] p0_wdata_c, p1_wdata_c, p0_rdata_c, p1_rdata_c, ram_in_c, ram_out_c;
    logic          p0_gnt_c, p1_gnt_c, p0_rvalid_c, p1_rvalid_c, ram_load_c, clear_busy_c;

    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_c [DEPTH];
    logic          init_done = 1'b0;

    logic [DW-1:0] shadow_a [DEPTH];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    sb_t           q_c[$];
    vec_t          vecs[17];

    int n_checks = 0;
    int n_fail   = 0;

    ram16k_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b0)) u_dut_a (
        .CLK(clk), .RST_N(rst_n_a),
        .p0_req(p0_req_a), .p0_we(p0_we_a), .p0_addr(p0_addr_a), .p0_wdata(p0_wdata_a),
        .p0_gnt(p0_gnt_a), .p0_rvalid(p0_rvalid_a), .p0_rdata(p0_rdata_a),
        .p1_req(p1_req_a), .p1_we(p1_we_a), .p1_addr(p1_addr_a), .p1_wdata(p1_wdata_a),
        .p1_gnt(p1_gnt_a), .p1_rvalid(p1_rvalid_a), .p1_rdata(p1_rdata_a),
        .ram_in(ram_in_a), .ram_address(ram_address_a), .ram_load(ram_load_a),
        .ram_out(ram_out_a), .clear_busy(clear_busy_a)
    );

    ram16k_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1)) u_dut_c (
        .CLK(clk), .RST_N(rst_n_c),
        .p0_req(p0_req_c), .p0_we(p0_we_c), .p0_addr(p0_addr_c), .p0_wdata(p0_wdata_c),
        .p0_gnt(p0_gnt_c), .p0_rvalid(p0_rvalid_c), .p0_rdata(p0_rdata_c),
        .p1_req(p1_req_c), .p1_we(p1_we_c), .p1_addr(p1_addr_c), .p1_wdata(p1_wdata_c),
        .p1_gnt(p1_gnt_c), .p1_rvalid(p1_rvalid_c), .p1_rdata(p1_rdata_c),
        .ram_in(ram_in_c), .ram_address(ram_address_c), .ram_load(ram_load_c),
        .ram_out(ram_out_c), .clear_busy(clear_busy_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAMs: filled with nonzero garbage on the first edge, then written on load
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] <= 16'(i) ^ 16'h5A5A;
                mem_c[i] <= 16'(i) ^ 16'hA5A5;
            end
            init_done <= 1'b1;
        end else begin
            if (ram_load_a) mem_a[ram_address_a] <= ram_in_a;
            if (ram_load_c) mem_c[ram_address_c] <= ram_in_c;
        end
    end

    assign ram_out_a = mem_a[ram_address_a];
    assign ram_out_c = mem_c[ram_address_c];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r0, input logic w0, input logic [AW-1:0] a0,
                                input logic [DW-1:0] d0, input logic r1, input logic w1,
                                input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic g0, input logic g1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    initial begin
        int            bad;
        int            nonzero;
        logic          exp_rv0, exp_rv1, exp_g0;
        logic [DW-1:0] e;
        sb_t           s;

        //               r0 w0 a0        d0        r1 w1 a1        d1        g0 g1
        vecs[0]  = mk(0, 0, 14'h0000, 16'h0000, 1, 0, 14'h0000, 16'h0000, 0, 1);
        vecs[1]  = mk(1, 1, 14'h0005, 16'h7FFF, 0, 0, 14'h0000, 16'h0000, 1, 0);
        vecs[2]  = mk(1, 0, 14'h0005, 16'h0000, 0, 0, 14'h0000, 16'h0000, 1, 0);
        vecs[3]  = mk(0, 0, 14'h0000, 16'h0000, 0, 0, 14'h0000, 16'h0000, 0, 0);
        vecs[4]  = mk(1, 0, 14'h0005, 16'h0000, 1, 0, 14'h0000, 16'h0000, 0, 1);
        vecs[5]  = mk(1, 0, 14'h0005, 16'h0000, 1, 0, 14'h0001, 16'h0000, 1, 0);
        vecs[6]  = mk(1, 0, 14'h0002, 16'h0000, 1, 0, 14'h0001, 16'h0000, 0, 1);
        vecs[7]  = mk(1, 0, 14'h0002, 16'h0000, 1, 0, 14'h0003, 16'h0000, 1, 0);
        vecs[8]  = mk(1, 0, 14'h0004, 16'h0000, 1, 0, 14'h0003, 16'h0000, 0, 1);
        vecs[9]  = mk(1, 0, 14'h0004, 16'h0000, 0, 0, 14'h0000, 16'h0000, 1, 0);
        vecs[10] = mk(1, 0, 14'h3FFF, 16'h0000, 1, 1, 14'h3FFF, 16'hFFFF, 0, 1);
        vecs[11] = mk(1, 0, 14'h3FFF, 16'h0000, 0, 0, 14'h0000, 16'h0000, 1, 0);
        vecs[12] = mk(1, 1, 14'h0010, 16'h8000, 0, 0, 14'h0000, 16'h0000, 1, 0);
        vecs[13] = mk(1, 0, 14'h0010, 16'h0000, 0, 0, 14'h0000, 16'h0000, 1, 0);
        vecs[14] = mk(0, 0, 14'h0000, 16'h0000, 1, 1, 14'h0010, 16'h1234, 0, 1);
        vecs[15] = mk(1, 0, 14'h0010, 16'h0000, 0, 0, 14'h0000, 16'h0000, 1, 0);
        vecs[16] = mk(0, 0, 14'h0000, 16'h0000, 0, 0, 14'h0000, 16'h0000, 0, 0);

        for (int i = 0; i < DEPTH; i++) shadow_a[i] = 16'(i) ^ 16'h5A5A;

        rst_n_a = 1'b0; rst_n_c = 1'b0;
        p0_req_a = 0; p0_we_a = 0; p0_addr_a = '0; p0_wdata_a = '0;
        p1_req_a = 0; p1_we_a = 0; p1_addr_a = '0; p1_wdata_a = '0;
        p0_req_c = 0; p0_we_c = 0; p0_addr_c = 14'h0001; p0_wdata_c = '0;
        p1_req_c = 0; p1_we_c = 0; p1_addr_c = 14'h0002; p1_wdata_c = '0;

        @(posedge clk); #1;
        @(posedge clk); #1;

        // ---- reset values, both instances ----
        check("c_rst_busy",   clear_busy_c, 1);
        check("c_rst_load",   ram_load_c, 1);
        check("c_rst_addr",   ram_address_c, 0);
        check("c_rst_rvalid", {p0_rvalid_c, p1_rvalid_c}, 0);
        check("c_rst_rdata",  {p0_rdata_c, p1_rdata_c}, 0);
        check("a_rst_busy",   clear_busy_a, 0);
        check("a_rst_load",   ram_load_a, 0);
        check("a_rst_rvalid", {p0_rvalid_a, p1_rvalid_a}, 0);

        // ---- sweep with both ports requesting; aborted by reset at count 100 ----
        p0_req_c = 1; p1_req_c = 1;
        rst_n_c = 1'b1;
        bad = 0;
        for (int j = 0; j < 100; j++) begin
            #3;
            if (ram_address_c !== 14'(j) || clear_busy_c !== 1'b1 || ram_load_c !== 1'b1 ||
                ram_in_c !== 16'h0 || p0_gnt_c !== 1'b0 || p1_gnt_c !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        #3;
        check("c_sweep1_errs", bad, 0);
        check("c_pre_rst_addr", ram_address_c, 100);
        rst_n_c = 1'b0;
        #1;
        check("c_midrst_addr", ram_address_c, 0);
        check("c_midrst_busy", clear_busy_c, 1);
        check("c_midrst_gnt",  {p0_gnt_c, p1_gnt_c}, 0);
        @(posedge clk); #1;
        rst_n_c = 1'b1;

        // ---- full restarted sweep: exactly DEPTH cycles, addresses 0..DEPTH-1 ----
        bad = 0;
        for (int j = 0; j < DEPTH; j++) begin
            #3;
            if (ram_address_c !== 14'(j) || clear_busy_c !== 1'b1 || ram_load_c !== 1'b1 ||
                ram_in_c !== 16'h0 || p0_gnt_c !== 1'b0 || p1_gnt_c !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        #3;
        check("c_sweep2_errs", bad, 0);
        check("c_busy_done", clear_busy_c, 0);
        nonzero = 0;
        for (int i = 0; i < DEPTH; i++) if (mem_c[i] !== 16'h0) nonzero++;
        check("c_backdoor_nonzero", nonzero, 0);

        // ---- continuous contention: p0, p1, p0, ... starting with p0 ----
        for (int k = 0; k < 8; k++) begin
            exp_g0 = (k % 2 == 0);
            check("c_rr_gnt0", p0_gnt_c, exp_g0);
            check("c_rr_gnt1", p1_gnt_c, !exp_g0);
            check("c_rr_both", p0_gnt_c & p1_gnt_c, 0);
            if (q_c.size() > 0) begin
                s = q_c.pop_front();
                check("c_rr_rvalid", {p1_rvalid_c, p0_rvalid_c}, s.port ? 2'b10 : 2'b01);
                check("c_rr_rdata", s.port ? p1_rdata_c : p0_rdata_c, s.data);
            end
            s.port = !exp_g0; s.data = 16'h0000;
            q_c.push_back(s);
            @(posedge clk); #4;
        end
        s = q_c.pop_front();
        check("c_rr_last_rvalid", {p1_rvalid_c, p0_rvalid_c}, s.port ? 2'b10 : 2'b01);
        check("c_rr_last_rdata", s.port ? p1_rdata_c : p0_rdata_c, s.data);
        p0_req_c = 0; p1_req_c = 0;

        // ---- no-clear instance: table of vectors, first one in the first cycle after reset ----
        @(posedge clk); #1;
        rst_n_a = 1'b1;
        exp_rv0 = 0; exp_rv1 = 0;
        for (int i = 0; i < 17; i++) begin
            p0_req_a = vecs[i].r0; p0_we_a = vecs[i].w0; p0_addr_a = vecs[i].a0; p0_wdata_a = vecs[i].d0;
            p1_req_a = vecs[i].r1; p1_we_a = vecs[i].w1; p1_addr_a = vecs[i].a1; p1_wdata_a = vecs[i].d1;
            #3;
            check($sformatf("v%0d_gnt0", i), p0_gnt_a, vecs[i].g0);
            check($sformatf("v%0d_gnt1", i), p1_gnt_a, vecs[i].g1);
            check($sformatf("v%0d_busy", i), clear_busy_a, 0);
            check($sformatf("v%0d_load", i), ram_load_a,
                  vecs[i].g1 ? vecs[i].w1 : (vecs[i].g0 ? vecs[i].w0 : 1'b0));
            check($sformatf("v%0d_addr", i), ram_address_a, vecs[i].g1 ? vecs[i].a1 : vecs[i].a0);
            check($sformatf("v%0d_in", i), ram_in_a, vecs[i].g1 ? vecs[i].d1 : vecs[i].d0);
            check($sformatf("v%0d_rvalid0", i), p0_rvalid_a, exp_rv0);
            check($sformatf("v%0d_rvalid1", i), p1_rvalid_a, exp_rv1);
            if (exp_rv0) begin
                if (q0.size() == 0) check("sb0_empty", 1, 0);
                else begin e = q0.pop_front(); check($sformatf("v%0d_rdata0", i), p0_rdata_a, e); end
            end
            if (exp_rv1) begin
                if (q1.size() == 0) check("sb1_empty", 1, 0);
                else begin e = q1.pop_front(); check($sformatf("v%0d_rdata1", i), p1_rdata_a, e); end
            end
            exp_rv0 = vecs[i].g0 && !vecs[i].w0;
            exp_rv1 = vecs[i].g1 && !vecs[i].w1;
            if (exp_rv0) q0.push_back(shadow_a[vecs[i].a0]);
            if (exp_rv1) q1.push_back(shadow_a[vecs[i].a1]);
            if (vecs[i].g0 && vecs[i].w0) shadow_a[vecs[i].a0] = vecs[i].d0;
            if (vecs[i].g1 && vecs[i].w1) shadow_a[vecs[i].a1] = vecs[i].d1;
            @(posedge clk); #1;
        end
        check("sb_leftover", q0.size() + q1.size(), 0);

        // ---- reset during an rvalid pulse squashes it ----
        p0_req_a = 1; p0_we_a = 0; p0_addr_a = 14'h0005;
        #3;
        check("sq_gnt0", p0_gnt_a, 1);
        @(posedge clk); #1;
        p0_req_a = 0;
        #1;
        check("sq_rvalid_before", p0_rvalid_a, 1);
        check("sq_rdata_before",  p0_rdata_a, 16'h7FFF);
        rst_n_a = 1'b0;
        #1;
        check("sq_rvalid_after", p0_rvalid_a, 0);
        check("sq_rdata0_after", p0_rdata_a, 0);
        check("sq_rdata1_after", p1_rdata_a, 0);

        // ---- after reset the first tie goes to port 0 ----
        @(posedge clk); #1;
        rst_n_a = 1'b1;
        p0_req_a = 1; p0_we_a = 0; p0_addr_a = 14'h0000;
        p1_req_a = 1; p1_we_a = 0; p1_addr_a = 14'h0000;
        #3;
        check("tie_gnt0", p0_gnt_a, 1);
        check("tie_gnt1", p1_gnt_a, 0);
        @(posedge clk); #1;
        p0_req_a = 0; p1_req_a = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram16k_arbiter.md
# ram16k_arbiter

Sequencer and two-port arbiter in front of the 16K-word data RAM of the Hack computer. After reset it zeroes all 16384 words, so contents are defined in hardware and not only in simulation. It then shares the RAM's single read/write port between two requesters: port 0 (CPU data memory) and port 1 (loader/DMA). Grants are round-robin. Read data is returned registered, one cycle after grant.

## Interface
- ADDR_W, 14, RAM address width; depth is 2^ADDR_W words
- DATA_W, 16, word width (signed two's-complement, passed through unmodified)
- CLEAR_ON_RESET, 1, 1 = run the zero-fill sweep after every reset; 0 = go straight to arbitration
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  reset, asynchronous assert, active-low
- pN_req  in  1  request from port N (N = 0, 1); held high until granted
- pN_we  in  1  1 = write, 0 = read; qualified by pN_req
- pN_addr  in  ADDR_W  word address
- pN_wdata  in  DATA_W  write data
- pN_gnt  out  1  combinational grant; the transaction completes at the rising edge where pN_req && pN_gnt
- pN_rvalid  out  1  one-cycle pulse, the cycle after a granted read
- pN_rdata  out  DATA_W  read data, valid while pN_rvalid is high; holds until the next read on that port
- ram_in  out  DATA_W  to RAM write data
- ram_address  out  ADDR_W  to RAM address
- ram_load  out  1  to RAM write enable
- ram_out  in  DATA_W  from RAM, combinational read of ram_address
- clear_busy  out  1  high while the zero-fill sweep runs

## Operation
- States: CLEAR, ARB.
- Reset state is CLEAR if CLEAR_ON_RESET = 1, else ARB.
- CLEAR behaviour:
  - ram_load = 1, ram_in = 0, ram_address = clr_cnt.
  - clr_cnt increments each cycle from 0.
  - After the cycle with clr_cnt = 2^ADDR_W − 1, state goes to ARB.
  - clr_cnt wraps to 0 and is unused in ARB.
  - All pN_gnt = 0 and clear_busy = 1 throughout CLEAR.
- ARB behaviour:
  - At most one grant per cycle.
  - If only one port requests, that port is granted.
  - If both request, the port other than `last` is granted. `last` is a register holding the most recently granted port, updated on each grant.
- Mux: ram_address, ram_in and ram_load = pN_we follow the granted port. With no grant, ram_load = 0, ram_address = p0_addr and ram_in = p0_wdata.
- Granted read: ram_out is captured into pN_rdata at the grant edge; pN_rvalid = 1 for the following cycle only.
- Granted write: the RAM commits at the grant edge; no rvalid.
- Requests made while ungranted are not dropped. The requester keeps req/we/addr/wdata stable until granted.

## Timing
- Reset values: state per CLEAR_ON_RESET, clr_cnt = 0, last = 1 (so p0 wins the first tie), pN_rvalid = 0, pN_rdata = 0, clear_busy = CLEAR_ON_RESET.
- Clear duration: exactly 2^ADDR_W cycles (16384) from the first edge after RST_N rises.
- Read latency: rdata/rvalid appear 1 cycle after the grant edge.
- Back-to-back: a port can be granted every cycle while the other is idle.
- Fairness: under continuous contention grants alternate p0, p1, p0, …; worst-case wait is 1 cycle.
- Read-after-write: a write at edge k followed by a read of the same address granted at edge k+1 returns the new data. Any port may issue either access.
- Same-cycle write/read from different ports: only one is granted. The loser's access happens next cycle and sees the post-write RAM state.
- RST_N asserted mid-CLEAR or mid-transaction: immediate return to reset values. The sweep restarts from address 0. An in-flight rvalid is squashed.

## Structure
- Shared package ram16k_arb_pkg holds:
  - state encoding constants ST_CLEAR and ST_ARB
  - RAM_ADDR_W = 14, RAM_DEPTH = 16384, WORD_W = 16
- Sub-module rr_arb2: two-requester round-robin arbiter.
  - Inputs: req[1:0], CLK, RST_N.
  - Outputs: gnt[1:0], one-hot or zero.
  - Owns the `last` register.
  - Instantiated once; enabled only in ARB.
- Top level holds the FSM, clr_cnt, the address/data mux and the read-return registers.

## Test plan
- Reset with CLEAR_ON_RESET=1, no requests:
  - clear_busy = 1 for 16384 cycles; ram_load = 1 with ram_address stepping 0→16383; then ARB.
  - Backdoor check: every RAM word = 0.
- p0 writes 16'sh7FFF to address 0x0005; next cycle p0 reads 0x0005 → p0_rvalid pulses 1 cycle later with p0_rdata = 0x7FFF.
- p0 and p1 both request reads continuously → grants alternate p0, p1, p0, …, starting with p0; no cycle has both gnt high.
- p1 writes −1 (0xFFFF) to 0x3FFF while p0 reads 0x3FFF in the same cycle:
  - p1 is granted first if last = 0.
  - p0's delayed read returns 0xFFFF.
- RST_N pulsed low at sweep count 100 → outputs return to reset values at once; after release the sweep restarts at address 0 and lasts the full 16384 cycles.
- CLEAR_ON_RESET=0: a p1 read at address 0x0000 is granted in the first cycle after reset; no clear cycles occur.
